// File: rtl/bloco_controle_if.sv
// Control bundle between bloco_controle and the bloco_operacional datapath.
// master = control unit, slave = datapath/requester side.
interface bloco_controle_if;
  logic       start;
  logic [7:0] X;
  logic       Overflow;
  logic       LX;
  logic       LS;
  logic       LH;
  logic       H;
  logic [1:0] M0;
  logic [1:0] M1;
  logic [1:0] M2;
  logic       busy;
  logic       done;
  logic       ovf;

  modport master (
    input  start, X, Overflow,
    output LX, LS, LH, H, M0, M1, M2, busy, done, ovf
  );

  modport slave (
    output start, X, Overflow,
    input  LX, LS, LH, H, M0, M1, M2, busy, done, ovf
  );
endinterface

// File: rtl/bloco_controle.sv
// Control unit sequencing bloco_operacional to compute A*X + B by repeated addition.
// Optional macro CTRL_SUBC_EN adds a SUBC step so the result becomes A*X + B - C.
module bloco_controle (
  input  logic              clk,
  input  logic              rst_n,
  bloco_controle_if.master  ctl
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    MUL  = 3'd2,
    ADDB = 3'd3,
    SUBC = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [7:0] cnt;
  logic       ovf_q;

  logic       lx;
  logic       ls;
  logic       lh;
  logic       h;
  logic [1:0] m0;
  logic [1:0] m1;
  logic [1:0] m2;
  logic       busy;
  logic       done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Overflow is sampled only in the accumulate states; LOAD just clears RS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= 8'd0;
      ovf_q <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          cnt   <= ctl.X;
          ovf_q <= 1'b0;
        end
        MUL: begin
          cnt   <= cnt - 8'd1;
          ovf_q <= ovf_q | ctl.Overflow;
        end
        ADDB: ovf_q <= ovf_q | ctl.Overflow;
`ifdef CTRL_SUBC_EN
        SUBC: ovf_q <= ovf_q | ctl.Overflow;
`endif
        default: begin
          cnt   <= cnt;
          ovf_q <= ovf_q;
        end
      endcase
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (ctl.start) next_state = LOAD;
      LOAD: next_state = (ctl.X == 8'd0) ? ADDB : MUL;
      MUL:  if (cnt == 8'd1) next_state = ADDB;
`ifdef CTRL_SUBC_EN
      ADDB: next_state = SUBC;
      SUBC: next_state = DONE;
`else
      ADDB: next_state = DONE;
`endif
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    lx   = 1'b0;
    ls   = 1'b0;
    lh   = 1'b0;
    h    = 1'b0;
    m0   = 2'd0;
    m1   = 2'd0;
    m2   = 2'd0;
    done = 1'b0;
    busy = (state != IDLE);
    case (state)
      LOAD: begin
        lx = 1'b1;
        ls = 1'b1;
        m2 = 2'd1;
      end
      MUL: begin
        ls = 1'b1;
        m0 = 2'd1;
        m2 = 2'd2;
      end
      ADDB: begin
        ls = 1'b1;
        m0 = 2'd2;
        m2 = 2'd2;
      end
`ifdef CTRL_SUBC_EN
      SUBC: begin
        ls = 1'b1;
        m0 = 2'd3;
        m2 = 2'd2;
        h  = 1'b1;
      end
`endif
      DONE: done = 1'b1;
      default: begin
        lx = 1'b0;
      end
    endcase
  end

  assign ctl.LX   = lx;
  assign ctl.LS   = ls;
  assign ctl.LH   = lh;
  assign ctl.H    = h;
  assign ctl.M0   = m0;
  assign ctl.M1   = m1;
  assign ctl.M2   = m2;
  assign ctl.busy = busy;
  assign ctl.done = done;
  assign ctl.ovf  = ovf_q;

endmodule
